// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: accepts one word-aligned request at a time and
// completes it with a single data_data_ok pulse after a fixed latency.
// Writes merge the enabled byte lanes into the addressed word. Reads return
// the full word, which is held in data_rdata until the next read completes.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic                    req_wr;
  logic [3:0]              req_wstrb;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic [31:0]             req_wdata;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [DEPTH];

  logic accept;
  logic done;

  // Byte-offset bits and address bits above the RAM depth carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  assign accept       = (state == IDLE) && data_req;
  assign done         = (state == BUSY) && (cnt == 4'd0);
  assign data_addr_ok = (state == IDLE);
  assign data_data_ok = (state == RESP);
  assign data_rdata   = rdata_q;

  // Next-state logic for the IDLE -> BUSY -> RESP handshake.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (data_req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Request capture, latency countdown and read-data register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= 4'd0;
      req_wr    <= 1'b0;
      req_wstrb <= 4'd0;
      req_idx   <= '0;
      req_wdata <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      if (accept) begin
        cnt       <= CNT_LOAD;
        req_wr    <= data_wr;
        req_wstrb <= data_wstrb;
        req_idx   <= data_addr[ADDR_WIDTH+1:2];
        req_wdata <= data_wdata;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (done && !req_wr) rdata_q <= mem[req_idx];
    end
  end

  // Byte-lane merged write into the RAM array on completion.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; a reset
    // cannot corrupt it because state is forced to IDLE, which keeps done low.
    if (done && req_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a vector table of single accesses
// on a LATENCY=2 and a LATENCY=1 instance, plus hand sequences for held
// back-to-back requests and reset in the middle of a write.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0, req1;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok0, aok1, dok0, dok1;
  logic [31:0] rd0, rd1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
    .clk(clk), .resetn(resetn), .data_req(req0), .data_wr(wr),
    .data_wstrb(wstrb), .data_addr(addr), .data_wdata(wdata),
    .data_addr_ok(aok0), .data_data_ok(dok0), .data_rdata(rd0)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .data_req(req1), .data_wr(wr),
    .data_wstrb(wstrb), .data_addr(addr), .data_wdata(wdata),
    .data_addr_ok(aok1), .data_data_ok(dok1), .data_rdata(rd1)
  );

  typedef struct {
    bit          d1;
    logic        wr;
    logic [3:0]  st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One complete access: wait for addr_ok, accept, count edges to data_ok,
  // confirm the pulse lasts one cycle. Returns rdata on the data_ok cycle.
  task automatic access(input bit d1, input logic w, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output bit one_pulse);
    bit ok;
    rd = 32'hx; lat = -1; one_pulse = 1'b0; ok = 1'b0;
    @(negedge clk);
    wr = w; wstrb = st; addr = a; wdata = wd;
    if (d1) req1 = 1'b1; else req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ((d1 ? aok1 : aok0) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if ((d1 ? dok1 : dok0) === 1'b1) begin
        lat = n;
        rd  = d1 ? rd1 : rd0;
        break;
      end
    end
    if (lat < 0) return;
    @(posedge clk);
    #1;
    one_pulse = ((d1 ? dok1 : dok0) === 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          one;
    int          pulses;
    int          first_idle;

    vecs[0]  = '{0, 1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2, "full_write"};
    vecs[1]  = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2, "read_full"};
    vecs[2]  = '{0, 1'b1, 4'b0100, 32'h0000_0012, 32'h5555_5555, 32'hDEAD_BEEF, 2, "byte_write"};
    vecs[3]  = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'hDE55_BEEF, 2, "read_byte_merge"};
    vecs[4]  = '{0, 1'b1, 4'b1100, 32'h0000_0012, 32'h1234_1234, 32'hDE55_BEEF, 2, "half_write"};
    vecs[5]  = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'h1234_BEEF, 2, "read_half_merge"};
    vecs[6]  = '{0, 1'b1, 4'b1111, 32'h0000_1010, 32'hCAFE_F00D, 32'h1234_BEEF, 2, "alias_write"};
    vecs[7]  = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2, "read_alias"};
    vecs[8]  = '{0, 1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'hCAFE_F00D, 2, "null_strobe_write"};
    vecs[9]  = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2, "read_after_null"};
    vecs[10] = '{1, 1'b1, 4'b1111, 32'h0000_0040, 32'h1122_3344, 32'h0000_0000, 1, "l1_write"};
    vecs[11] = '{1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0,         32'h1122_3344, 1, "l1_read"};
    vecs[12] = '{1, 1'b1, 4'b1111, 32'h0000_0040, 32'hAAAA_AAAA, 32'h1122_3344, 1, "l1_write_keeps_rdata"};
    vecs[13] = '{1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0,         32'hAAAA_AAAA, 1, "l1_read2"};

    req0 = 1'b0; req1 = 1'b0; wr = 1'b0; wstrb = 4'd0; addr = 32'd0; wdata = 32'd0;
    resetn = 1'b0;
    #2;
    check("reset_addr_ok", {31'd0, aok0}, 32'd1);
    check("reset_data_ok", {31'd0, dok0}, 32'd0);
    check("reset_rdata",   rd0,           32'd0);
    check("reset_rdata_l1", rd1,          32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 14; v++) begin
      access(vecs[v].d1, vecs[v].wr, vecs[v].st, vecs[v].addr, vecs[v].wd, rd, lat, one);
      check({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].exp_lat));
      check({vecs[v].name, "_rdata"},   rd,       vecs[v].exp_rd);
      check({vecs[v].name, "_one_pulse"}, {31'd0, one}, 32'd1);
    end

    // Held request across two back-to-back reads on the LATENCY=2 instance.
    @(negedge clk);
    wr = 1'b0; wstrb = 4'd0; addr = 32'h0000_0010; wdata = 32'd0;
    req0 = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0; first_idle = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) req0 = 1'b0;
      if (k <= 2) check($sformatf("b2b_addr_ok_low_e%0d", k), {31'd0, aok0}, 32'd0);
      if (aok0 === 1'b1 && first_idle == 0) first_idle = k;
      if (dok0 === 1'b1) pulses++;
    end
    check("b2b_second_accept_edge", 32'(first_idle + 1), 32'd4);
    check("b2b_pulse_count",        32'(pulses),         32'd2);
    check("b2b_rdata",              rd0,                 32'hCAFE_F00D);

    // Reset in the middle of a write to word 0x20.
    access(0, 1'b1, 4'b1111, 32'h0000_0020, 32'h0000_0000, rd, lat, one);
    check("rst_prewrite_latency", 32'(lat), 32'd2);
    @(negedge clk);
    wr = 1'b1; wstrb = 4'b1111; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF;
    req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy_addr_ok", {31'd0, aok0}, 32'd0);
    resetn = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (dok0 === 1'b1) pulses++;
    end
    check("rst_addr_ok", {31'd0, aok0}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (dok0 === 1'b1) pulses++;
    end
    check("rst_no_data_ok", 32'(pulses), 32'd0);
    access(0, 1'b0, 4'b0000, 32'h0000_0020, 32'd0, rd, lat, one);
    check("rst_read_latency", 32'(lat), 32'd2);
    check("rst_read_word",    rd,       32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time limit so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data-access port.
- Accepts word-aligned requests that carry the 4-bit byte write enables and the lane-replicated write data produced by the CPU memory-access formatter.
- Performs byte-lane-merged writes or full-word reads on an internal word-addressed RAM, with a fixed, parameterised response latency.
- Used as the data RAM model behind the MEM stage for simulation and FPGA bring-up.

Parameters:
ADDR_WIDTH, 10, word-index bits; RAM depth 2^ADDR_WIDTH words; byte address bits above ADDR_WIDTH+1 ignored (aliasing).
LATENCY, 2, cycles from address acceptance to data_ok; legal range 1..15 (4-bit counter).

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous, active-low reset
data_req  input  1  request valid; requester holds it and all request fields stable until data_addr_ok
data_wr  input  1  1 = write, 0 = read
data_wstrb  input  4  byte write enables, bit i -> bits [8i+7:8i]; ignored on reads
data_addr  input  32  byte address; bits [1:0] ignored
data_wdata  input  32  write data, already lane-replicated by requester
data_addr_ok  output  1  request accepted this cycle when high together with data_req
data_data_ok  output  1  one-cycle completion pulse
data_rdata  output  32  read data word

Behaviour:
- States: IDLE, BUSY, RESP. Reset (resetn low, asynchronous) forces IDLE, data_data_ok=0, data_rdata=0, latency counter=0.
- data_addr_ok = (state==IDLE), combinational from state only (no dependence on data_req). Reads 1 while in reset.
- Accept: rising edge with state==IDLE and data_req=1.
  - Latch data_wr, data_wstrb, word index data_addr[ADDR_WIDTH+1:2] and data_wdata.
  - Load counter with LATENCY-1; go to BUSY.
- BUSY, each edge:
  - If counter != 0: decrement.
  - If counter == 0 and write: update each byte lane whose latched strobe bit is 1; other lanes are unchanged.
  - If counter == 0 and read: register mem[index] into data_rdata.
  - In both counter == 0 cases, set data_data_ok=1 and go to RESP.
- RESP: data_data_ok high for exactly this one cycle. Next edge clears data_data_ok and returns to IDLE.
- Timing:
  - Accept at edge E0 -> data_data_ok high between edges E_LATENCY and E_LATENCY+1.
  - Earliest next accept is edge E_LATENCY+2; at most one outstanding request.
- data_rdata holds its value until the next read completes; writes do not change it.
  - Read data is the full word; byte/halfword extraction and extension are the requester's job.
- Write with data_wstrb=0000: RAM unchanged; still completes with one data_data_ok pulse.
- data_req while in BUSY or RESP is ignored, with no buffering. The request is accepted on return to IDLE if still asserted.
- Reset mid-operation:
  - The pending access is discarded and no RAM write occurs.
  - No data_data_ok is issued for it.
  - RAM contents are not cleared by reset.
- RAM is uninitialised at power-up; reads of unwritten words return X in simulation.
- Exactly one data_data_ok per accepted request; never a data_data_ok without a prior accept.

Test Plan:
1. LATENCY=2, after reset: write 0x00000010, wstrb 1111, wdata 0xDEADBEEF. data_data_ok pulses once, 2 edges after accept. Then read 0x00000010 -> data_rdata=0xDEADBEEF on its data_ok cycle.
2. Byte write 0x00000012, wstrb 0100, wdata 0x55555555 -> read 0x10 returns 0xDE55BEEF. Then halfword write 0x12, wstrb 1100, wdata 0x12341234 -> read returns 0x1234BEEF.
3. data_req held continuously across two back-to-back requests: data_addr_ok low during BUSY/RESP. Second accept occurs exactly at E0+LATENCY+2; two data_data_ok pulses total.
4. Reset mid-write: word 0x20 previously written 0x00000000; request write of 0xFFFFFFFF; pull resetn low while BUSY. data_data_ok stays 0 and a subsequent read of 0x20 returns 0x00000000.
5. Aliasing and null strobe (ADDR_WIDTH=10): write 0x00001010, wstrb 1111, wdata 0xCAFEF00D -> read 0x00000010 returns 0xCAFEF00D. Then write 0x10 with wstrb 0000 -> completes and data still 0xCAFEF00D.
6. LATENCY=1 (separate elaboration): read completes with data_data_ok on the edge after accept. data_rdata is unchanged by an intervening write.
